wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 wb_rd  in  5  writeback destination register address (from the MEM/WB register).
REQ-004 wb_we  in  1  writeback enable.
REQ-005 wb_data  in  32  writeback value.
REQ-006 rs1_addr  in  5  source register 1 address from decode.
REQ-007 rs2_addr  in  5  source register 2 address from decode.
REQ-008 rs1_data  out  32  source 1 value, combinational.
REQ-009 rs2_data  out  32  source 2 value, combinational.
REQ-010 iss_valid  in  1  decode presents an instruction for issue this cycle.
REQ-011 iss_we  in  1  issuing instruction writes a destination register.
REQ-012 iss_rd  in  5  issuing instruction's destination address.
REQ-013 stall  out  1  issue blocked this cycle; combinational.
REQ-014 busy_vec  out  32  bit i = register i has at least one outstanding write; bit 0 always 0.
REQ-015 sb_err  out  1  sticky scoreboard underflow flag.

Function
REQ-016 Storage: 31 x 32-bit registers x1..x31; x0 has no storage.
REQ-017 Write: at the clock edge, reg[wb_rd] <= wb_data when wb_we=1, wb_rd!=0 and rst=0.
REQ-018 Read: rsN_data = 0 when rsN_addr=0; else wb_data when wb_we=1 and wb_rd=rsN_addr (write-through bypass); else reg[rsN_addr].
REQ-019 Scoreboard: per register x1..x31, a 2-bit pending counter cnt[i], range 0..3.
REQ-020 Issue accept: acc = iss_valid & ~stall.
REQ-021 inc_i = acc & iss_we & (iss_rd=i) & (i!=0); dec_i = wb_we & (wb_rd=i) & (i!=0).
REQ-022 Counter update: inc & ~dec -> +1; dec & ~inc -> -1; inc & dec -> unchanged; neither -> unchanged.
REQ-023 Underflow: dec_i with cnt[i]=0 and no inc_i leaves cnt[i] at 0 and sets sb_err=1; sb_err stays 1 until reset.
REQ-024 Source hazard for rsN (N=1,2), rsN_addr!=0: hzN = (cnt[rsN_addr]>=2) | (cnt[rsN_addr]=1 & ~(wb_we & wb_rd=rsN_addr)).
REQ-025 Destination hazard: hzd = iss_we & (iss_rd!=0) & (cnt[iss_rd]=3).
REQ-026 stall = iss_valid & (hz1 | hz2 | hzd); stall=0 whenever iss_valid=0.
REQ-027 Source hazards are evaluated for both rs1_addr and rs2_addr regardless of instruction format; decode drives 0 for an unused source.
REQ-028 A source register pending with cnt=1 and written back in the same cycle does not stall; the bypass value of REQ-018 is used.
REQ-029 busy_vec[i] = (cnt[i]!=0), registered state only; it does not reflect same-cycle inc/dec.
REQ-030 Issue with iss_we=0 or iss_rd=0 never changes any counter.
REQ-031 Latency: a write is visible through the array one cycle after wb_we and through the bypass in the same cycle.

Reset
REQ-032 While rst=1 at an edge: all registers <= 0, all cnt <= 0, sb_err <= 0; the wb write and issue increment for that edge are suppressed.
REQ-033 After reset: rs1_data=rs2_data=0 (absent bypass), busy_vec=0, stall=0, sb_err=0.
REQ-034 Reset asserted with writes outstanding discards them; later dec on a cleared counter sets sb_err per REQ-023.

Verification
REQ-035 Reset, then wb_we=1 wb_rd=5 wb_data=0xDEADBEEF, rs1_addr=5 -> rs1_data=0xDEADBEEF same cycle (bypass) and next cycle with wb_we=0 (array).
REQ-036 wb_we=1 wb_rd=0 wb_data=0x12345678, then rs1_addr=0 -> rs1_data=0; busy_vec[0]=0; sb_err=0.
REQ-037 Issue iss_we=1 iss_rd=7 -> busy_vec[7]=1 next cycle; issue rs2_addr=7 -> stall=1; same with wb_we=1 wb_rd=7 wb_data=0x55 -> stall=0, rs2_data=0x55, busy_vec[7]=0 next cycle.
REQ-038 Three accepted issues to x9 -> cnt[9]=3; fourth issue to x9 -> stall=1 and cnt unchanged; same cycle wb x9 plus issue to x9 -> still stall=1 (REQ-025 uses registered cnt); wb x9 alone -> cnt=2; next issue to x9 accepted.
REQ-039 cnt[3]=1, simultaneous accepted issue to x3 and wb to x3 -> cnt[3]=1 afterwards, busy_vec[3]=1; wb to x4 with cnt[4]=0 -> sb_err=1 and held until rst.
REQ-040 With cnt[2]=2 and reg x2=0xAA, assert rst for one cycle -> busy_vec=0, rs1_data(x2)=0, stall=0, sb_err=0.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - register file with write-through bypass and pending-write scoreboard
// x0 has no storage and reads as zero. Each of x1..x31 has a 2-bit outstanding-write counter that gates issue.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_rd,
    input  logic        wb_we,
    input  logic [31:0] wb_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        iss_valid,
    input  logic        iss_we,
    input  logic [4:0]  iss_rd,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic        sb_err
);

    logic [31:0] regs_q [1:31];
    logic [1:0]  cnt_q  [1:31];
    logic [1:0]  cnt_d  [1:31];
    logic        sb_err_q;
    logic        sb_err_d;

    logic [31:0] rs1_arr;
    logic [31:0] rs2_arr;
    logic [1:0]  cnt_rs1;
    logic [1:0]  cnt_rs2;
    logic [1:0]  cnt_rd;
    logic        hz1;
    logic        hz2;
    logic        hzd;
    logic        acc;

    always_comb begin
        rs1_arr = '0;
        rs2_arr = '0;
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_addr == 5'(i)) begin
                rs1_arr = regs_q[i];
                cnt_rs1 = cnt_q[i];
            end
            if (rs2_addr == 5'(i)) begin
                rs2_arr = regs_q[i];
                cnt_rs2 = cnt_q[i];
            end
            if (iss_rd == 5'(i)) begin
                cnt_rd = cnt_q[i];
            end
        end
    end

    always_comb begin
        if (rs1_addr == 5'd0)                   rs1_data = '0;
        else if (wb_we && (wb_rd == rs1_addr))  rs1_data = wb_data;
        else                                    rs1_data = rs1_arr;
        if (rs2_addr == 5'd0)                   rs2_data = '0;
        else if (wb_we && (wb_rd == rs2_addr))  rs2_data = wb_data;
        else                                    rs2_data = rs2_arr;
    end

    // A single pending write that retires this cycle is covered by the bypass, so it does not block.
    assign hz1 = (rs1_addr != 5'd0) &&
                 ((cnt_rs1 >= 2'd2) || ((cnt_rs1 == 2'd1) && !(wb_we && (wb_rd == rs1_addr))));
    assign hz2 = (rs2_addr != 5'd0) &&
                 ((cnt_rs2 >= 2'd2) || ((cnt_rs2 == 2'd1) && !(wb_we && (wb_rd == rs2_addr))));
    assign hzd = iss_we && (iss_rd != 5'd0) && (cnt_rd == 2'd3);

    assign stall = iss_valid && (hz1 || hz2 || hzd);
    assign acc   = iss_valid && !stall;

    always_comb begin
        sb_err_d = sb_err_q;
        for (int i = 1; i < 32; i++) begin
            logic inc;
            logic dec;
            inc      = acc && iss_we && (iss_rd == 5'(i));
            dec      = wb_we && (wb_rd == 5'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (dec && !inc) begin
                if (cnt_q[i] == 2'd0) sb_err_d = 1'b1;
                else                  cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wb_we && (wb_rd == 5'(i))) regs_q[i] <= wb_data;
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = (cnt_q[i] != 2'd0);
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        iss_valid;
    logic        iss_we;
    logic [4:0]  iss_rd;
    logic        stall;
    logic [31:0] busy_vec;
    logic        sb_err;

    int passed = 0;
    int total  = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd),
        .stall(stall), .busy_vec(busy_vec), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        rs1_addr = 0; rs2_addr = 0;
        iss_valid = 0; iss_we = 0; iss_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        iss_valid = 1; iss_we = 1; iss_rd = rd;
        tick();
        iss_valid = 0; iss_we = 0; iss_rd = 0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        wb_we = 1; wb_rd = 5'd6; wb_data = 32'hFFFF_0000;
        iss_valid = 1; iss_we = 1; iss_rd = 5'd6;
        tick();
        idle();
        rs1_addr = 5'd6; rs2_addr = 5'd3;
        #1;
        total++; if (rs1_data !== 32'h0) $display("FAIL reset_rs1 got %h exp %h", rs1_data, 32'h0); else passed++;
        total++; if (rs2_data !== 32'h0) $display("FAIL reset_rs2 got %h exp %h", rs2_data, 32'h0); else passed++;
        total++; if (busy_vec !== 32'h0) $display("FAIL reset_busy got %h exp %h", busy_vec, 32'h0); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL reset_sb_err got %b exp 0", sb_err); else passed++;
        iss_valid = 1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'h1234_5678; rs1_addr = 5'd0;
        #1;
        total++; if (rs1_data !== 32'h0) $display("FAIL x0_bypass got %h exp %h", rs1_data, 32'h0); else passed++;
        tick();
        wb_we = 0;
        #1;
        total++; if (rs1_data !== 32'h0) $display("FAIL x0_array got %h exp %h", rs1_data, 32'h0); else passed++;
        total++; if (busy_vec[0] !== 1'b0) $display("FAIL x0_busy got %b exp 0", busy_vec[0]); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL x0_sb_err got %b exp 0", sb_err); else passed++;
    endtask

    task automatic test_bypass();
        do_reset();
        wb_we = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; rs1_addr = 5'd5; rs2_addr = 5'd4;
        #1;
        total++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL bypass_rs1 got %h exp %h", rs1_data, 32'hDEAD_BEEF); else passed++;
        total++; if (rs2_data !== 32'h0) $display("FAIL bypass_other got %h exp %h", rs2_data, 32'h0); else passed++;
        tick();
        wb_we = 0; rs2_addr = 5'd5;
        #1;
        total++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL array_rs1 got %h exp %h", rs1_data, 32'hDEAD_BEEF); else passed++;
        total++; if (rs2_data !== 32'hDEAD_BEEF) $display("FAIL array_rs2 got %h exp %h", rs2_data, 32'hDEAD_BEEF); else passed++;
        // x5 had nothing pending, so that writeback was an underflow
        total++; if (sb_err !== 1'b1) $display("FAIL bypass_underflow got %b exp 1", sb_err); else passed++;
    endtask

    task automatic test_raw_hazard();
        do_reset();
        iss_valid = 1; iss_we = 1; iss_rd = 5'd7;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL raw_first_issue got %b exp 0", stall); else passed++;
        tick();
        idle();
        #1;
        total++; if (busy_vec !== 32'h0000_0080) $display("FAIL raw_busy got %h exp %h", busy_vec, 32'h0000_0080); else passed++;
        rs2_addr = 5'd7;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL raw_no_valid got %b exp 0", stall); else passed++;
        iss_valid = 1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL raw_stall got %b exp 1", stall); else passed++;
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'h55;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL raw_wb_release got %b exp 0", stall); else passed++;
        total++; if (rs2_data !== 32'h55) $display("FAIL raw_wb_data got %h exp %h", rs2_data, 32'h55); else passed++;
        tick();
        idle();
        #1;
        total++; if (busy_vec !== 32'h0) $display("FAIL raw_busy_clear got %h exp %h", busy_vec, 32'h0); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL raw_sb_err got %b exp 0", sb_err); else passed++;
    endtask

    task automatic test_waw_saturate();
        do_reset();
        for (int k = 0; k < 3; k++) issue_wr(5'd9);
        total++; if (busy_vec !== 32'h0000_0200) $display("FAIL waw_busy got %h exp %h", busy_vec, 32'h0000_0200); else passed++;
        iss_valid = 1; iss_we = 1; iss_rd = 5'd9;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL waw_full_stall got %b exp 1", stall); else passed++;
        tick();
        wb_we = 1; wb_rd = 5'd9; wb_data = 32'h99;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL waw_wb_same_cycle got %b exp 1", stall); else passed++;
        tick();
        // count is now 2: a source read of x9 still stalls even with a writeback in flight
        iss_we = 0; iss_rd = 0; rs1_addr = 5'd9;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL waw_cnt2_src got %b exp 1", stall); else passed++;
        idle();
        iss_valid = 1; iss_we = 1; iss_rd = 5'd9;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL waw_reaccept got %b exp 0", stall); else passed++;
        tick();
        #1;
        total++; if (stall !== 1'b1) $display("FAIL waw_refull got %b exp 1", stall); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL waw_sb_err got %b exp 0", sb_err); else passed++;
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_wr(5'd3);
        iss_valid = 1; iss_we = 1; iss_rd = 5'd3;
        wb_we = 1; wb_rd = 5'd3; wb_data = 32'h33;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL b2b_stall got %b exp 0", stall); else passed++;
        tick();
        idle();
        #1;
        total++; if (busy_vec !== 32'h0000_0008) $display("FAIL b2b_busy got %h exp %h", busy_vec, 32'h0000_0008); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL b2b_sb_err got %b exp 0", sb_err); else passed++;
        wb_we = 1; wb_rd = 5'd4; wb_data = 32'h44;
        tick();
        idle();
        #1;
        total++; if (sb_err !== 1'b1) $display("FAIL underflow_set got %b exp 1", sb_err); else passed++;
        total++; if (busy_vec !== 32'h0000_0008) $display("FAIL underflow_busy got %h exp %h", busy_vec, 32'h0000_0008); else passed++;
        for (int k = 0; k < 4; k++) tick();
        total++; if (sb_err !== 1'b1) $display("FAIL underflow_sticky got %b exp 1", sb_err); else passed++;
        rst = 1;
        tick();
        rst = 0;
        #1;
        total++; if (sb_err !== 1'b0) $display("FAIL underflow_clear got %b exp 0", sb_err); else passed++;
    endtask

    task automatic test_reset_discard();
        do_reset();
        wb_we = 1; wb_rd = 5'd2; wb_data = 32'hAA;
        tick();
        idle();
        issue_wr(5'd2);
        issue_wr(5'd2);
        rs1_addr = 5'd2;
        #1;
        total++; if (busy_vec !== 32'h0000_0004) $display("FAIL discard_pre_busy got %h exp %h", busy_vec, 32'h0000_0004); else passed++;
        total++; if (rs1_data !== 32'hAA) $display("FAIL discard_pre_data got %h exp %h", rs1_data, 32'hAA); else passed++;
        rst = 1;
        tick();
        rst = 0;
        iss_valid = 1;
        #1;
        total++; if (busy_vec !== 32'h0) $display("FAIL discard_busy got %h exp %h", busy_vec, 32'h0); else passed++;
        total++; if (rs1_data !== 32'h0) $display("FAIL discard_data got %h exp %h", rs1_data, 32'h0); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL discard_stall got %b exp 0", stall); else passed++;
        total++; if (sb_err !== 1'b0) $display("FAIL discard_sb_err got %b exp 0", sb_err); else passed++;
        idle();
        wb_we = 1; wb_rd = 5'd2; wb_data = 32'h1;
        tick();
        idle();
        #1;
        total++; if (sb_err !== 1'b1) $display("FAIL discard_late_wb got %b exp 1", sb_err); else passed++;
    endtask

    initial begin
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_raw_hazard();
        test_waw_saturate();
        test_back_to_back();
        test_reset_discard();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
